// File: rtl/bat_ctrl_pkg.sv
// Shared constants for the BatAmateur microsequencer: opcode groups, microstep
// states and the idle control word.
package bat_ctrl_pkg;

   typedef enum logic [2:0] {S_F0, S_F1, S_E1, S_E2, S_E3, S_HALT} state_e;

   // Instruction group as decoded from INSTR[15:12]
   typedef enum logic [2:0] {C_REG, C_JMP, C_DMEM, C_IMEM, C_IJMP, C_EXT} iclass_e;

   localparam logic [3:0] OP_REG   = 4'b0111;
   localparam logic [3:0] OP_EXT   = 4'b1111;
   localparam logic [3:0] SUB_NOP  = 4'b0000;
   localparam logic [3:0] SUB_HALT = 4'b0001;
   localparam logic [3:0] SUB_CALL = 4'b0010;
   localparam logic [3:0] SUB_RET  = 4'b0011;
   localparam logic [4:0] ALU_MOV  = 5'b11111;
   localparam logic [4:0] ALU_INC  = 5'b11110;

   typedef struct packed {
      logic       pc_inc;
      logic       pc_rw;
      logic       pc_en;
      logic       mar_load;
      logic       mar_en;
      logic       ram_rw;
      logic       ram_en;
      logic       ir_load;
      logic       ir_en;
      logic       alu_en;
      logic [4:0] alu_op;
      logic       stk_en;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{pc_inc: 1'b0, pc_rw: 1'b1, pc_en: 1'b0, mar_load: 1'b0,
                                   mar_en: 1'b1, ram_rw: 1'b1, ram_en: 1'b0, ir_load: 1'b1,
                                   ir_en: 1'b0, alu_en: 1'b0, alu_op: 5'd0, stk_en: 1'b0};

   function automatic iclass_e iclass(input logic [3:0] op);
      if (op == OP_REG) return C_REG;
      if (op == OP_EXT) return C_EXT;
      case (op[3:2])
         2'b00:   return C_DMEM;
         2'b01:   return C_JMP;
         2'b10:   return C_IMEM;
         default: return C_IJMP;
      endcase
   endfunction

   // cc: 00 always, 01 on Z, 10 on !Z, 11 never
   function automatic logic cond_ok(input logic [1:0] cc, input logic z);
      case (cc)
         2'b00:   return 1'b1;
         2'b01:   return z;
         2'b10:   return !z;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/bat_sequencer_if.sv
// Control/status bus between the microsequencer (master) and the datapath (slave).
interface bat_sequencer_if #(
   parameter int NREGS  = 8,
   parameter int ADDR_W = 8
);
   logic [15:0]       INSTR;
   logic [7:0]        ALU_REG;
   logic              MEM_RDY;
   logic [ADDR_W-1:0] PC_VAL;
   logic              PC_INC, PC_RW, PC_EN;
   logic              MAR_LOAD, MAR_EN;
   logic              RAM_RW, RAM_EN;
   logic              IR_LOAD, IR_EN;
   logic [NREGS-1:0]  REGS_INC, REGS_RW, REGS_EN;
   logic              ALU_EN;
   logic [4:0]        ALU_OP;
   logic              STK_EN;
   logic [ADDR_W-1:0] STK_ADDR;
   logic              HALTED, STK_ERR;

   modport master (
      input  INSTR, ALU_REG, MEM_RDY, PC_VAL,
      output PC_INC, PC_RW, PC_EN, MAR_LOAD, MAR_EN, RAM_RW, RAM_EN, IR_LOAD, IR_EN,
             REGS_INC, REGS_RW, REGS_EN, ALU_EN, ALU_OP, STK_EN, STK_ADDR, HALTED, STK_ERR
   );

   modport slave (
      output INSTR, ALU_REG, MEM_RDY, PC_VAL,
      input  PC_INC, PC_RW, PC_EN, MAR_LOAD, MAR_EN, RAM_RW, RAM_EN, IR_LOAD, IR_EN,
             REGS_INC, REGS_RW, REGS_EN, ALU_EN, ALU_OP, STK_EN, STK_ADDR, HALTED, STK_ERR
   );
endinterface

// File: rtl/bat_ret_stack.sv
// Return-address LIFO for CALL/RET; pushes when full and pops when empty are ignored.
module bat_ret_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] top_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [CW-1:0] cnt_q;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign top_o   = empty_o ? '0 : mem_q[AW'(cnt_q - 1'b1)];

   always_ff @(negedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (push_i && !full_o) begin
         mem_q[AW'(cnt_q)] <= data_i;
         cnt_q             <= cnt_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end
endmodule

// File: rtl/bat_sequencer.sv
// Parametrised BatAmateur microsequencer, one microstep per falling clock edge.
// Optional CALL/RET return stack built when BAT_CALL_STACK_EN is defined.
module bat_sequencer
   import bat_ctrl_pkg::*;
#(
   parameter int NREGS       = 8,
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic            CLK,
   input  logic            RST,
   bat_sequencer_if.master bus
);
   state_e           state_q, state_d;
   iclass_e          cls;
   ctrl_t            ctrl;
   logic [NREGS-1:0] r_inc, r_rw, r_en, ab_oh;
   logic [4:0]       aop;
   logic [3:0]       sub;
   logic [2:0]       rx, ry;
   logic             st, cond, regs_ok, ir2mar, ir2pc, xfer;

`ifdef BAT_CALL_STACK_EN
   logic              stk_push, stk_pop, stk_full, stk_empty, stk_err_q, stk_err_d;
   logic [ADDR_W-1:0] stk_top;

   bat_ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stk (
      .clk_i(CLK), .rst_ni(RST), .push_i(stk_push), .pop_i(stk_pop), .data_i(bus.PC_VAL),
      .top_o(stk_top), .full_o(stk_full), .empty_o(stk_empty)
   );
`endif

   // Index decode; indices beyond the register file select nothing
   function automatic logic [NREGS-1:0] oh(input logic [2:0] i);
      for (int k = 0; k < NREGS; k++) oh[k] = (int'(i) == k);
   endfunction

   assign cls     = iclass(bus.INSTR[15:12]);
   assign aop     = bus.INSTR[11:7];
   assign sub     = bus.INSTR[11:8];
   assign rx      = bus.INSTR[5:3];
   assign ry      = bus.INSTR[2:0];
   assign st      = bus.INSTR[13];
   assign cond    = cond_ok(bus.INSTR[13:12], bus.ALU_REG[0]);
   assign regs_ok = (int'(rx) < NREGS) && (int'(ry) < NREGS);
   assign ab_oh   = bus.INSTR[12] ? oh(3'd1) : oh(3'd0);

   always_comb begin
      ctrl    = CTRL_IDLE;
      r_inc   = '0;
      r_rw    = '1;
      r_en    = '0;
      ir2mar  = 1'b0;
      ir2pc   = 1'b0;
      xfer    = 1'b0;
      state_d = state_q;
`ifdef BAT_CALL_STACK_EN
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_err_d = stk_err_q;
`endif
      case (state_q)
         S_F0: begin
            ctrl.pc_en    = 1'b1;
            ctrl.mar_load = 1'b1;
            state_d       = S_F1;
         end
         S_F1: begin
            ctrl.ram_en = 1'b1;
            ctrl.ir_en  = 1'b1;
            if (bus.MEM_RDY) begin
               ctrl.pc_inc = 1'b1;
               ctrl.pc_rw  = 1'b0;
            end
            state_d = S_E1;
         end
         S_E1: begin
            state_d = S_F0;
            case (cls)
               C_REG: if (regs_ok) begin
                  if (aop == ALU_MOV) begin
                     r_en = oh(rx) | oh(ry);
                     r_rw = ~oh(rx);
                  end else if (aop == ALU_INC) begin
                     r_inc = oh(rx);
                     r_rw  = ~oh(rx);
                  end else begin
                     state_d = S_E2;
                     if (rx != 3'd0) begin
                        r_en = oh(rx) | oh(3'd0);
                        r_rw = ~oh(3'd0);
                     end
                  end
               end
               C_JMP: ir2pc = cond;
               C_DMEM, C_IMEM, C_IJMP: begin
                  ir2mar  = 1'b1;
                  state_d = S_E2;
               end
               C_EXT: begin
                  if (sub == SUB_HALT) state_d = S_HALT;
`ifdef BAT_CALL_STACK_EN
                  // Stack misuse leaves the stack untouched and stops the machine
                  if (sub == SUB_CALL) begin
                     if (stk_full) begin
                        stk_err_d = 1'b1;
                        state_d   = S_HALT;
                     end else begin
                        stk_push = 1'b1;
                        ir2pc    = 1'b1;
                     end
                  end
                  if (sub == SUB_RET) begin
                     if (stk_empty) begin
                        stk_err_d = 1'b1;
                        state_d   = S_HALT;
                     end else begin
                        stk_pop     = 1'b1;
                        ctrl.stk_en = 1'b1;
                        ctrl.pc_en  = 1'b1;
                        ctrl.pc_rw  = 1'b0;
                     end
                  end
`endif
               end
               default: ;
            endcase
         end
         S_E2: begin
            state_d = S_F0;
            case (cls)
               C_REG: begin
                  state_d = S_E3;
                  if (ry != 3'd1) begin
                     r_en = oh(ry) | oh(3'd1);
                     r_rw = ~oh(3'd1);
                  end
               end
               C_DMEM: xfer = 1'b1;
               C_IMEM: begin
                  ctrl.ram_en   = 1'b1;
                  ctrl.mar_load = 1'b1;
                  state_d       = S_E3;
               end
               C_IJMP: if (cond) begin
                  ctrl.ram_en = 1'b1;
                  ctrl.pc_en  = 1'b1;
                  ctrl.pc_rw  = 1'b0;
               end
               default: ;
            endcase
         end
         S_E3: begin
            state_d = S_F0;
            if (cls == C_REG) begin
               ctrl.alu_en = 1'b1;
               ctrl.alu_op = aop;
               r_en        = bus.INSTR[6] ? oh(3'd0) : oh(3'd1);
               r_rw        = ~r_en;
            end
            if (cls == C_IMEM) xfer = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_F0;
      endcase

      if (ir2mar) begin
         ctrl.ir_en    = 1'b1;
         ctrl.ir_load  = 1'b0;
         ctrl.mar_load = 1'b1;
      end
      if (ir2pc) begin
         ctrl.ir_en   = 1'b1;
         ctrl.ir_load = 1'b0;
         ctrl.pc_en   = 1'b1;
         ctrl.pc_rw   = 1'b0;
      end
      // Store reads the selected A/B register; load writes it
      if (xfer) begin
         ctrl.ram_en = 1'b1;
         ctrl.ram_rw = ~st;
         r_en        = ab_oh;
         if (!st) r_rw = ~ab_oh;
      end
      if (ctrl.ram_en && !bus.MEM_RDY) state_d = state_q;
      if (!RST) begin
         ctrl  = CTRL_IDLE;
         r_inc = '0;
         r_rw  = '1;
         r_en  = '0;
      end
   end

   always_ff @(negedge CLK) begin
      if (!RST) state_q <= S_F0;
      else      state_q <= state_d;
   end

   assign bus.PC_INC   = ctrl.pc_inc;
   assign bus.PC_RW    = ctrl.pc_rw;
   assign bus.PC_EN    = ctrl.pc_en;
   assign bus.MAR_LOAD = ctrl.mar_load;
   assign bus.MAR_EN   = ctrl.mar_en;
   assign bus.RAM_RW   = ctrl.ram_rw;
   assign bus.RAM_EN   = ctrl.ram_en;
   assign bus.IR_LOAD  = ctrl.ir_load;
   assign bus.IR_EN    = ctrl.ir_en;
   assign bus.ALU_EN   = ctrl.alu_en;
   assign bus.ALU_OP   = ctrl.alu_op;
   assign bus.REGS_INC = r_inc;
   assign bus.REGS_RW  = r_rw;
   assign bus.REGS_EN  = r_en;
   assign bus.HALTED   = RST && (state_q == S_HALT);

   logic unused_flags;
   assign unused_flags = ^bus.ALU_REG[7:1];

`ifdef BAT_CALL_STACK_EN
   always_ff @(negedge CLK) begin
      if (!RST) stk_err_q <= 1'b0;
      else      stk_err_q <= stk_err_d;
   end

   assign bus.STK_EN   = ctrl.stk_en;
   assign bus.STK_ADDR = ctrl.stk_en ? stk_top : '0;
   assign bus.STK_ERR  = RST && stk_err_q;
`else
   localparam int unused_stack_depth = STACK_DEPTH;
   logic unused_stk;
   assign unused_stk   = ^{bus.PC_VAL, ctrl.stk_en};
   assign bus.STK_EN   = 1'b0;
   assign bus.STK_ADDR = '0;
   assign bus.STK_ERR  = 1'b0;
`endif
endmodule

// File: tb/tb_bat_sequencer.sv
// Directed bench for bat_sequencer: per-cycle control words checked against hand-built
// expectations; the CALL/RET checks follow the BAT_CALL_STACK_EN build.
module tb_bat_sequencer;
   logic CLK = 1'b0;
   logic RST;
   int   n_run = 0;
   int   n_fail = 0;

   bat_sequencer_if #(.NREGS(8), .ADDR_W(8)) bus ();
   bat_sequencer #(.NREGS(8), .ADDR_W(8), .STACK_DEPTH(2)) dut (
      .CLK(CLK), .RST(RST), .bus(bus.master)
   );

   always #5 CLK = ~CLK;

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   function automatic logic [15:0] sc(input logic pc_inc, pc_rw, pc_en, mar_load, mar_en,
                                      ram_rw, ram_en, ir_load, ir_en, alu_en,
                                      input logic [4:0] alu_op, input logic stk_en);
      return {pc_inc, pc_rw, pc_en, mar_load, mar_en, ram_rw, ram_en, ir_load, ir_en,
              alu_en, alu_op, stk_en};
   endfunction

   function automatic logic [23:0] rg(input logic [7:0] inc, rw, en);
      return {inc, rw, en};
   endfunction

   logic [15:0] got_sc;
   logic [23:0] got_rg;
   assign got_sc = {bus.PC_INC, bus.PC_RW, bus.PC_EN, bus.MAR_LOAD, bus.MAR_EN, bus.RAM_RW,
                    bus.RAM_EN, bus.IR_LOAD, bus.IR_EN, bus.ALU_EN, bus.ALU_OP, bus.STK_EN};
   assign got_rg = {bus.REGS_INC, bus.REGS_RW, bus.REGS_EN};

   logic [15:0] W_IDLE, W_F0, W_F1, W_F1W, W_IRMAR, W_JMP, W_RDMAR, W_RD, W_WR, W_RAMPC;
   logic [23:0] RG_IDLE;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Check this cycle's control word, then advance past the next falling edge
   task automatic cyc(input string tag, input logic [15:0] es, input logic [23:0] er);
      #1;
      chk({tag, ".ctl"}, {16'h0, got_sc}, {16'h0, es});
      chk({tag, ".regs"}, {8'h0, got_rg}, {8'h0, er});
      @(negedge CLK);
      #1;
   endtask

   task automatic fetch(input logic [15:0] ins);
      bus.INSTR   = ins;
      bus.MEM_RDY = 1'b1;
      cyc("F0", W_F0, RG_IDLE);
      cyc("F1", W_F1, RG_IDLE);
   endtask

   initial begin
      W_IDLE  = sc(0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 5'd0, 0);
      W_F0    = sc(0, 1, 1, 1, 1, 1, 0, 1, 0, 0, 5'd0, 0);
      W_F1    = sc(1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 5'd0, 0);
      W_F1W   = sc(0, 1, 0, 0, 1, 1, 1, 1, 1, 0, 5'd0, 0);
      W_IRMAR = sc(0, 1, 0, 1, 1, 1, 0, 0, 1, 0, 5'd0, 0);
      W_JMP   = sc(0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 5'd0, 0);
      W_RDMAR = sc(0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 5'd0, 0);
      W_RD    = sc(0, 1, 0, 0, 1, 1, 1, 1, 0, 0, 5'd0, 0);
      W_WR    = sc(0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 5'd0, 0);
      W_RAMPC = sc(0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 5'd0, 0);
      RG_IDLE = rg(8'h00, 8'hFF, 8'h00);

      RST         = 1'b0;
      bus.INSTR   = 16'h0000;
      bus.ALU_REG = 8'h00;
      bus.MEM_RDY = 1'b1;
      bus.PC_VAL  = 8'h00;
      @(negedge CLK);
      #1;
      chk("rst.halted", bus.HALTED, 0);
      chk("rst.stkerr", bus.STK_ERR, 0);
      cyc("rst", W_IDLE, RG_IDLE);
      RST = 1'b1;

      // ADD with both loads skipped: E1/E2 idle, B written in E3
      fetch(16'h7001);
      cyc("add.E1", W_IDLE, RG_IDLE);
      cyc("add.E2", W_IDLE, RG_IDLE);
      cyc("add.E3", sc(0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 5'd0, 0), rg(8'h00, 8'hFD, 8'h02));

      // ALU op 2, A<-r2, B<-r3, result to A
      fetch(16'h7153);
      cyc("alu.E1", W_IDLE, rg(8'h00, 8'hFE, 8'h05));
      cyc("alu.E2", W_IDLE, rg(8'h00, 8'hFD, 8'h0A));
      cyc("alu.E3", sc(0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 5'd2, 0), rg(8'h00, 8'hFE, 8'h01));

      fetch(16'h7F93);
      cyc("mov.E1", W_IDLE, rg(8'h00, 8'hFB, 8'h0C));
      fetch(16'h7F38);
      cyc("inc.E1", W_IDLE, rg(8'h80, 8'h7F, 8'h00));

      bus.ALU_REG = 8'h01;
      fetch(16'h5042);
      cyc("jz.taken", W_JMP, RG_IDLE);
      bus.ALU_REG = 8'h00;
      fetch(16'h5042);
      cyc("jz.skip", W_IDLE, RG_IDLE);
      fetch(16'h6010);
      cyc("jnz.taken", W_JMP, RG_IDLE);

      // Fetch with one wait state: PC_INC only on the ready cycle
      bus.INSTR = 16'h4000;
      cyc("jmp.F0", W_F0, RG_IDLE);
      bus.MEM_RDY = 1'b0;
      cyc("jmp.F1w", W_F1W, RG_IDLE);
      bus.MEM_RDY = 1'b1;
      cyc("jmp.F1", W_F1, RG_IDLE);
      cyc("jmp.E1", W_JMP, RG_IDLE);

      fetch(16'h1020);
      cyc("ldb.E1", W_IRMAR, RG_IDLE);
      cyc("ldb.E2", W_RD, rg(8'h00, 8'hFD, 8'h02));

      fetch(16'hA005);
      cyc("ista.E1", W_IRMAR, RG_IDLE);
      bus.MEM_RDY = 1'b0;
      cyc("ista.E2w0", W_RDMAR, RG_IDLE);
      cyc("ista.E2w1", W_RDMAR, RG_IDLE);
      bus.MEM_RDY = 1'b1;
      cyc("ista.E2", W_RDMAR, RG_IDLE);
      cyc("ista.E3", W_WR, rg(8'h00, 8'hFF, 8'h01));

      fetch(16'hC010);
      cyc("ijmp.E1", W_IRMAR, RG_IDLE);
      cyc("ijmp.E2", W_RAMPC, RG_IDLE);
      bus.ALU_REG = 8'h01;
      fetch(16'hE010);
      cyc("ijnz.E1", W_IRMAR, RG_IDLE);
      cyc("ijnz.E2", W_IDLE, RG_IDLE);
      bus.ALU_REG = 8'h00;

`ifndef BAT_CALL_STACK_EN
      fetch(16'hF200);
      #1;
      chk("call.nop.addr", bus.STK_ADDR, 0);
      cyc("call.nop", W_IDLE, RG_IDLE);
      fetch(16'hF300);
      cyc("ret.nop", W_IDLE, RG_IDLE);
`endif

      fetch(16'hF100);
      chk("halt.E1", bus.HALTED, 0);
      cyc("halt.E1", W_IDLE, RG_IDLE);
      for (int i = 0; i < 10; i++) begin
         chk("halt.flag", bus.HALTED, 1);
         cyc("halt.idle", W_IDLE, RG_IDLE);
      end
      RST = 1'b0;
      #1;
      chk("halt.rst", bus.HALTED, 0);
      cyc("halt.rst", W_IDLE, RG_IDLE);
      RST = 1'b1;
      fetch(16'h0000);
      cyc("lda.E1", W_IRMAR, RG_IDLE);
      cyc("lda.E2", W_RD, rg(8'h00, 8'hFE, 8'h01));

`ifdef BAT_CALL_STACK_EN
      // Depth-2 stack: third CALL overflows and halts
      bus.PC_VAL = 8'h11;
      fetch(16'hF205);
      cyc("call1", W_JMP, RG_IDLE);
      bus.PC_VAL = 8'h22;
      fetch(16'hF206);
      cyc("call2", W_JMP, RG_IDLE);
      bus.PC_VAL = 8'h33;
      fetch(16'hF207);
      cyc("call3", W_IDLE, RG_IDLE);
      chk("ovf.halted", bus.HALTED, 1);
      chk("ovf.err", bus.STK_ERR, 1);
      RST = 1'b0;
      cyc("ovf.rst", W_IDLE, RG_IDLE);
      RST = 1'b1;
      chk("rst.err", bus.STK_ERR, 0);
      bus.PC_VAL = 8'h44;
      fetch(16'hF208);
      cyc("call4", W_JMP, RG_IDLE);
      bus.PC_VAL = 8'h99;
      fetch(16'hF300);
      #1;
      chk("ret.addr", bus.STK_ADDR, 8'h44);
      cyc("ret", sc(0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 5'd0, 1), RG_IDLE);
      fetch(16'hF300);
      cyc("ret.empty", W_IDLE, RG_IDLE);
      chk("udf.halted", bus.HALTED, 1);
      chk("udf.err", bus.STK_ERR, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
